// File: rtl/s3_maxpool_stream.sv
// Streaming 2x2 signed max-pool for a 4-filter 6x6 feature map (36 pooled outputs per frame).
// Horizontal pairs are reduced on the fly; even-row pair maxima wait in a 3-entry line buffer.
module s3_maxpool_stream #(
  parameter int unsigned DWIDTH = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        out_ch,
  output logic [1:0]        out_row,
  output logic [1:0]        out_col,
  output logic              frame_done
);

  logic [2:0]                   col_q, col_d, row_q, row_d;
  logic [1:0]                   ch_q, ch_d;
  logic [DWIDTH-1:0]            hold_q, hold_d;
  logic [2:0][DWIDTH-1:0]       lb_q, lb_d;
  logic [DWIDTH-1:0]            data_q, data_d;
  logic [1:0]                   och_q, och_d, orow_q, orow_d, ocol_q, ocol_d;
  logic                         valid_q, valid_d, done_q, done_d;
  logic                         xfer;
  logic [DWIDTH-1:0]            pair, pool;

  assign in_ready = !(valid_q && !out_ready);
  assign xfer     = in_valid && in_ready;

  assign pair = ($signed(in_data) > $signed(hold_q)) ? in_data : hold_q;
  assign pool = ($signed(pair) > $signed(lb_q[col_q[2:1]])) ? pair : lb_q[col_q[2:1]];

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    ch_d    = ch_q;
    hold_d  = hold_q;
    lb_d    = lb_q;
    data_d  = data_q;
    och_d   = och_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if (valid_q && out_ready) valid_d = 1'b0;

    // Abort wins over a simultaneous transfer; the offered sample is dropped.
    if (clear) begin
      col_d   = '0;
      row_d   = '0;
      ch_d    = '0;
      hold_d  = '0;
      lb_d    = '0;
      valid_d = 1'b0;
    end else if (xfer) begin
      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        lb_d[col_q[2:1]] = pair;
      end else begin
        data_d  = pool;
        och_d   = ch_q;
        orow_d  = row_q[2:1];
        ocol_d  = col_q[2:1];
        valid_d = 1'b1;
      end

      if (col_q == 3'd5) begin
        col_d = '0;
        if (row_q == 3'd5) begin
          row_d = '0;
          ch_d  = ch_q + 2'd1;
          if (ch_q == 2'd3) done_d = 1'b1;
        end else begin
          row_d = row_q + 3'd1;
        end
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      hold_q  <= '0;
      lb_q    <= '0;
      data_q  <= '0;
      och_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      hold_q  <= hold_d;
      lb_q    <= lb_d;
      data_q  <= data_d;
      och_q   <= och_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_ch     = och_q;
  assign out_row    = orow_q;
  assign out_col    = ocol_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_s3_maxpool_stream.sv
// Scoreboard bench for s3_maxpool_stream: expected pooled results are queued as inputs are
// transferred and compared when the DUT hands them off downstream.
module tb_s3_maxpool_stream;

  localparam int unsigned DW = 36;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch, out_row, out_col;
  logic          frame_done;

  s3_maxpool_stream #(.DWIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  int n_fd     = 0;
  bit bp_arm   = 1'b0;
  logic [DW-1:0] first_data, last_data;
  logic [DW+5:0] exp_q[$];
  logic signed [DW-1:0] frame [144];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic fill_frame(input int pat);
    for (int i = 0; i < 144; i++) begin
      if (pat == 0) frame[i] = DW'((i / 36) * 1000 + ((i % 36) / 6) * 6 + (i % 6));
      else          frame[i] = {4'($urandom_range(0, 15)), 32'($urandom)};
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap, input bit clr);
    int waits;
    @(negedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (gap) begin @(negedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    clear    = clr;
    waits    = 0;
    while (!in_ready && waits < 100) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic run_frame(input int n, input int gap_max, input int clr_at);
    int ch, r, c;
    for (int i = 0; i < n; i++) begin
      send(frame[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0, i == clr_at);
      ch = i / 36; r = (i % 36) / 6; c = i % 6;
      if (i != clr_at && r[0] && c[0])
        exp_q.push_back({2'(ch), 2'(r / 2), 2'(c / 2),
                         smax(smax(frame[i-7], frame[i-6]), smax(frame[i-1], frame[i]))});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  task automatic end_frame(input string tag, input int exp_out, input int exp_fd);
    idle(4);
    check({tag, "_n_out"}, 64'(n_out), 64'(exp_out));
    check({tag, "_n_fd"}, 64'(n_fd), 64'(exp_fd));
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    n_out = 0;
    n_fd  = 0;
  endtask

  // Downstream sink: optional one-shot stall, frame_done tracking, scoreboard pop.
  initial begin
    logic [DW+5:0] snap, e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && bp_arm) begin
        bp_arm    = 1'b0;
        out_ready = 1'b0;
        snap      = {out_ch, out_row, out_col, out_data};
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_hold", 64'({out_valid, out_ch, out_row, out_col, out_data}),
                64'({1'b1, snap}));
        end
        out_ready = 1'b1;
      end
      if (frame_done) begin
        n_fd++;
        check("fd_last", 64'({out_valid, out_ch, out_row, out_col}),
              64'({1'b1, 2'd3, 2'd2, 2'd2}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'({out_ch, out_row, out_col, out_data}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out", 64'({out_ch, out_row, out_col, out_data}), 64'(e));
          if (n_out == 0) first_data = out_data;
          last_data = out_data;
          n_out++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_out", 64'({out_ch, out_row, out_col, out_data}), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // Gapless reference frame.
    fill_frame(0);
    run_frame(144, 0, -1);
    end_frame("f1", 36, 1);
    check("f1_first", 64'(first_data), 64'd7);
    check("f1_last", 64'(last_data), 64'd3035);

    // All-negative first window plus a 10-cycle downstream stall on the first output.
    fill_frame(0);
    frame[0] = -5; frame[1] = -2; frame[6] = -9; frame[7] = -3;
    bp_arm = 1'b1;
    run_frame(144, 0, -1);
    end_frame("f2", 36, 1);
    check("f2_first_neg", 64'(first_data), 64'(36'hFFFFFFFFE));

    // Same data as the reference frame with random input gaps.
    fill_frame(0);
    run_frame(144, 2, -1);
    end_frame("f3", 36, 1);
    check("f3_last", 64'(last_data), 64'd3035);

    // Abort at sample 50: 12 outputs precede it, nothing after.
    fill_frame(1);
    run_frame(51, 1, 50);
    idle(1);
    check("clr_valid", 64'(out_valid), 64'd0);
    end_frame("f4", 12, 0);

    fill_frame(1);
    run_frame(144, 1, -1);
    end_frame("f5", 36, 1);

    // Reset mid-frame after 80 samples: 19 outputs were already produced.
    fill_frame(1);
    run_frame(80, 0, -1);
    @(negedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_out", 64'({out_valid, frame_done, out_ch, out_row, out_col, out_data}),
          64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    end_frame("f6", 19, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_ready_after", 64'(in_ready), 64'd1);

    fill_frame(0);
    run_frame(144, 1, -1);
    end_frame("f7", 36, 1);
    check("f7_first", 64'(first_data), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
